meteor_field: RTL and testbench

- Parametrised successor to the single-wave obstacle block.
- Manages OBJ_NUM falling meteors. Each meteor has its own state machine, LFSR-randomised spawn X and speed, and a staggered respawn delay.
- Checks AMMO_NUM bullets against every meteor each frame, with per-bullet consume pulses and a saturating hit counter.
- Sits between the bullet/ship logic and the sprite renderer; advances once per frame_clk.

---
 rtl/meteor_field_pkg.sv | 14 +
 rtl/meteor_field_if.sv | 33 +++
 rtl/meteor_field_lfsr.sv | 19 +
 rtl/meteor_field.sv | 180 ++++++++++++++++++
 tb/tb_meteor_field.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/meteor_field_pkg.sv
// Shared types and helpers for the meteor field: per-meteor state encoding,
// LFSR taps and the spawn X folding function.
package meteor_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, EXPLODE} obj_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fold a 10-bit random value into [0, range) with a single subtract.
  function automatic logic [9:0] spawn_x(input logic [15:0] lfsr, input logic [9:0] range);
    return (lfsr[9:0] >= range) ? (lfsr[9:0] - range) : lfsr[9:0];
  endfunction

endpackage

// File: rtl/meteor_field_if.sv
// Bullet inputs and meteor/score outputs exchanged with the ship logic and renderer.
interface meteor_field_if #(
  parameter int OBJ_NUM  = 8,
  parameter int AMMO_NUM = 2,
  parameter int COORD_W  = 10,
  parameter int CNT_W    = 16
);
  logic                        enable;
  logic [AMMO_NUM*COORD_W-1:0] ammo_x;
  logic [AMMO_NUM*COORD_W-1:0] ammo_y;
  logic [AMMO_NUM-1:0]         ammo_valid;
  logic [OBJ_NUM*COORD_W-1:0]  obj_x;
  logic [OBJ_NUM*COORD_W-1:0]  obj_y;
  logic [COORD_W-1:0]          obj_size;
  logic [OBJ_NUM-1:0]          obj_active;
  logic [OBJ_NUM-1:0]          obj_exploding;
  logic [AMMO_NUM-1:0]         ammo_hit;
  logic                        hit_pulse;
  logic                        miss_pulse;
  logic [CNT_W-1:0]            hit_count;

  modport master (
    output enable, ammo_x, ammo_y, ammo_valid,
    input  obj_x, obj_y, obj_size, obj_active, obj_exploding,
           ammo_hit, hit_pulse, miss_pulse, hit_count
  );

  modport slave (
    input  enable, ammo_x, ammo_y, ammo_valid,
    output obj_x, obj_y, obj_size, obj_active, obj_exploding,
           ammo_hit, hit_pulse, miss_pulse, hit_count
  );
endinterface

// File: rtl/meteor_field_lfsr.sv
// 16-bit right-shifting Galois LFSR; holds its value while i_en is low.
module lfsr_galois16
  import meteor_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_seed,
  input  logic        i_en,
  output logic [15:0] o_state
);
  logic [15:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_state <= i_seed;
    else if (i_en) r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
  end

  assign o_state = r_state;
endmodule

// File: rtl/meteor_field.sv
// OBJ_NUM falling meteors with randomised spawn, per-bullet collision and a
// saturating destroy counter; advances once per enabled frame.
module meteor_field
  import meteor_pkg::*;
#(
  parameter int          OBJ_NUM        = 8,
  parameter int          AMMO_NUM       = 2,
  parameter int          COORD_W        = 10,
  parameter int          OBJ_SIZE       = 30,
  parameter int          SCREEN_W       = 640,
  parameter int          SCREEN_H       = 480,
  parameter int          RESPAWN_FRAMES = 16,
  parameter int          EXPLODE_FRAMES = 8,
  parameter int          CNT_W          = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
)(
  input logic           i_frame_clk,
  input logic           i_reset,
  meteor_field_if.slave bus
);
  localparam int            CW      = COORD_W;
  localparam int            TW      = $clog2(RESPAWN_FRAMES + EXPLODE_FRAMES + OBJ_NUM + 2);
  localparam logic [CW:0]   SIZE_X  = (CW+1)'(OBJ_SIZE);
  localparam logic [CW:0]   H_X     = (CW+1)'(SCREEN_H);
  localparam logic [9:0]    X_RANGE = 10'(SCREEN_W - OBJ_SIZE);

  logic [15:0]                      w_lfsr;
  logic [OBJ_NUM-1:0][CW-1:0]       w_x, w_y;
  logic [OBJ_NUM-1:0]               w_act, w_expl, w_elig, w_spawn, w_destroy, w_miss;
  logic [AMMO_NUM-1:0][CW:0]        w_ax, w_ay;
  logic [AMMO_NUM-1:0][OBJ_NUM-1:0] w_hm;
  logic [AMMO_NUM-1:0]              w_ahit;
  logic [CNT_W:0]                   w_sum;

  logic [AMMO_NUM-1:0] r_ahit;
  logic                r_hit, r_miss;
  logic [CNT_W-1:0]    r_hcnt;

  lfsr_galois16 u_lfsr (
    .i_clk   (i_frame_clk),
    .i_rst   (i_reset),
    .i_seed  (LFSR_SEED),
    .i_en    (bus.enable),
    .o_state (w_lfsr)
  );

  always_comb begin
    w_ax = '0;
    w_ay = '0;
    for (int j = 0; j < AMMO_NUM; j++) begin
      w_ax[j] = {1'b0, bus.ammo_x[j*CW +: CW]};
      w_ay[j] = {1'b0, bus.ammo_y[j*CW +: CW]};
    end
  end

  // A bullet claims only the lowest-index meteor it is strictly inside.
  always_comb begin
    w_hm      = '0;
    w_destroy = '0;
    w_ahit    = '0;
    for (int j = 0; j < AMMO_NUM; j++) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        if (bus.ammo_valid[j] && w_act[i] &&
            ({1'b0, w_x[i]} < w_ax[j]) && (w_ax[j] < {1'b0, w_x[i]} + SIZE_X) &&
            ({1'b0, w_y[i]} < w_ay[j]) && (w_ay[j] < {1'b0, w_y[i]} + SIZE_X))
          w_hm[j][i] = 1'b1;
      end
      w_destroy = w_destroy | (w_hm[j] & (~w_hm[j] + OBJ_NUM'(1)));
      w_ahit[j] = |w_hm[j];
    end
  end

  assign w_spawn = w_elig & (~w_elig + OBJ_NUM'(1));

  always_comb begin
    w_sum = {1'b0, r_hcnt};
    for (int i = 0; i < OBJ_NUM; i++) w_sum = w_sum + (CNT_W+1)'(w_destroy[i]);
  end

  always_ff @(posedge i_frame_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ahit <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_hcnt <= '0;
    end else if (!bus.enable) begin
      r_ahit <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_ahit <= w_ahit;
      r_hit  <= |w_destroy;
      r_miss <= |w_miss;
      r_hcnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  for (genvar i = 0; i < OBJ_NUM; i++) begin : g_obj
    obj_state_t    r_state, w_nxt;
    logic [TW-1:0] r_cnt;
    logic [CW-1:0] r_x, r_y;
    logic [2:0]    r_spd;
    logic [CW:0]   w_ny;
    logic          w_exit, w_is_act, w_is_expl;

    // Counter value 1 means it reaches zero on this edge, so spawning is already allowed.
    assign w_ny       = {1'b0, r_y} + (CW+1)'(r_spd);
    assign w_exit     = (w_ny >= H_X);
    assign w_elig[i]  = (r_state == IDLE) && (r_cnt <= TW'(1));
    assign w_miss[i]  = (r_state == ACTIVE) && !w_destroy[i] && w_exit;
    assign w_x[i]     = r_x;
    assign w_y[i]     = r_y;
    assign w_act[i]   = w_is_act;
    assign w_expl[i]  = w_is_expl;

    always_ff @(posedge i_frame_clk or posedge i_reset) begin
      if (i_reset)         r_state <= IDLE;
      else if (bus.enable) r_state <= w_nxt;
    end

    always_comb begin
      w_nxt = r_state;
      unique case (r_state)
        IDLE:    if (w_spawn[i]) w_nxt = ACTIVE;
        ACTIVE:  if (w_destroy[i]) w_nxt = EXPLODE;
                 else if (w_exit)  w_nxt = IDLE;
        EXPLODE: if (r_cnt == '0)  w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end

    always_comb begin
      w_is_act  = (r_state == ACTIVE);
      w_is_expl = (r_state == EXPLODE);
    end

    always_ff @(posedge i_frame_clk or posedge i_reset) begin
      if (i_reset) begin
        r_cnt <= TW'(i + 1);
        r_x   <= '0;
        r_y   <= '0;
        r_spd <= 3'd1;
      end else if (bus.enable) begin
        unique case (r_state)
          IDLE: begin
            if (w_spawn[i]) begin
              r_x   <= CW'(spawn_x(w_lfsr, X_RANGE));
              r_y   <= '0;
              r_spd <= (w_lfsr[15:13] == 3'd0) ? 3'd1 : w_lfsr[15:13];
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - TW'(1);
            end
          end
          ACTIVE: begin
            if (w_destroy[i]) r_cnt <= TW'(EXPLODE_FRAMES - 1);
            else begin
              r_y <= w_ny[CW-1:0];
              if (w_exit) r_cnt <= TW'(RESPAWN_FRAMES);
            end
          end
          EXPLODE: begin
            if (r_cnt == '0) r_cnt <= TW'(RESPAWN_FRAMES);
            else             r_cnt <= r_cnt - TW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.obj_x         = w_x;
  assign bus.obj_y         = w_y;
  assign bus.obj_size      = CW'(OBJ_SIZE);
  assign bus.obj_active    = w_act;
  assign bus.obj_exploding = w_expl;
  assign bus.ammo_hit      = r_ahit;
  assign bus.hit_pulse     = r_hit;
  assign bus.miss_pulse    = r_miss;
  assign bus.hit_count     = r_hcnt;
endmodule

// File: tb/tb_meteor_field.sv
// Drives meteor_field with directed and random frames and compares every
// output against a frame-level game model after each edge.
module tb_meteor_field;
  localparam int N = 8, A = 2, CW = 10, CNTW = 16;
  localparam int SZ = 30, SW = 640, SH = 480, RESP = 16, EXPL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  meteor_field_if #(.OBJ_NUM(N), .AMMO_NUM(A), .COORD_W(CW), .CNT_W(CNTW)) bus ();

  meteor_field #(.OBJ_NUM(N), .AMMO_NUM(A), .COORD_W(CW), .OBJ_SIZE(SZ), .SCREEN_W(SW),
                 .SCREEN_H(SH), .RESPAWN_FRAMES(RESP), .EXPLODE_FRAMES(EXPL), .CNT_W(CNTW),
                 .LFSR_SEED(16'hACE1))
    dut (.i_frame_clk(clk), .i_reset(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // model: 0 = waiting to spawn, 1 = falling, 2 = blowing up
  int m_st[N], m_cnt[N], m_x[N], m_y[N], m_spd[N];
  int m_lfsr, m_hits;
  bit [A-1:0] e_ahit;
  bit e_hp, e_mp;
  int t_ax[A], t_ay[A];
  bit t_av[A];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_cnt[i] = i + 1; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 1;
    end
    m_lfsr = 'hACE1; m_hits = 0; e_ahit = '0; e_hp = 0; e_mp = 0;
  endtask

  task automatic model_step(input bit en);
    bit tgt[N];
    int sp, nh, lx, sv;
    bit miss;
    e_ahit = '0; e_hp = 0; e_mp = 0;
    if (!en) return;
    for (int i = 0; i < N; i++) tgt[i] = 0;
    for (int j = 0; j < A; j++)
      if (t_av[j])
        for (int i = 0; i < N; i++)
          if (m_st[i] == 1 && m_x[i] < t_ax[j] && t_ax[j] < m_x[i] + SZ &&
              m_y[i] < t_ay[j] && t_ay[j] < m_y[i] + SZ) begin
            e_ahit[j] = 1; tgt[i] = 1; break;
          end
    sp = -1;
    for (int i = 0; i < N; i++) if (m_st[i] == 0 && m_cnt[i] <= 1) begin sp = i; break; end
    nh = 0; miss = 0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 0) begin
        if (i == sp) begin
          lx = m_lfsr % 1024;
          if (lx >= SW - SZ) lx -= SW - SZ;
          sv = m_lfsr / 8192;
          m_st[i] = 1; m_x[i] = lx; m_y[i] = 0; m_spd[i] = (sv == 0) ? 1 : sv;
        end else if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (m_st[i] == 1) begin
        if (tgt[i]) begin m_st[i] = 2; m_cnt[i] = EXPL - 1; nh++; end
        else begin
          m_y[i] += m_spd[i];
          if (m_y[i] >= SH) begin m_st[i] = 0; m_cnt[i] = RESP; miss = 1; end
        end
      end else begin
        if (m_cnt[i] == 0) begin m_st[i] = 0; m_cnt[i] = RESP; end
        else m_cnt[i]--;
      end
    end
    sv = m_lfsr;
    m_lfsr = sv / 2;
    if (sv % 2 == 1) m_lfsr = m_lfsr ^ 'hB400;
    m_hits = (m_hits + nh > 65535) ? 65535 : m_hits + nh;
    e_hp = (nh > 0); e_mp = miss;
  endtask

  task automatic check_all();
    logic [N*CW-1:0] ex, ey;
    logic [N-1:0] ea, ee;
    int l;
    for (int i = 0; i < N; i++) begin
      ex[i*CW +: CW] = CW'(m_x[i]);
      ey[i*CW +: CW] = CW'(m_y[i]);
      ea[i] = (m_st[i] == 1);
      ee[i] = (m_st[i] == 2);
    end
    l = m_lfsr;
    chk("obj_x", 128'(bus.obj_x), 128'(ex));
    chk("obj_y", 128'(bus.obj_y), 128'(ey));
    chk("obj_active", 128'(bus.obj_active), 128'(ea));
    chk("obj_exploding", 128'(bus.obj_exploding), 128'(ee));
    chk("ammo_hit", 128'(bus.ammo_hit), 128'(e_ahit));
    chk("hit_pulse", 128'(bus.hit_pulse), 128'(e_hp));
    chk("miss_pulse", 128'(bus.miss_pulse), 128'(e_mp));
    chk("hit_count", 128'(bus.hit_count), 128'(m_hits));
    chk("lfsr", 128'(dut.u_lfsr.r_state), 128'(l[15:0]));
  endtask

  task automatic frame(input bit en, input bit [A-1:0] av, input int ax0, input int ay0,
                       input int ax1, input int ay1);
    t_av[0] = av[0]; t_av[1] = av[1];
    t_ax[0] = ax0; t_ay[0] = ay0; t_ax[1] = ax1; t_ay[1] = ay1;
    bus.enable = en;
    bus.ammo_valid = av;
    bus.ammo_x = {CW'(ax1), CW'(ax0)};
    bus.ammo_y = {CW'(ay1), CW'(ay0)};
    model_step(en);
    @(posedge clk); #1;
    check_all();
  endtask

  function automatic int pick_active();
    int s = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) if (m_st[(s + k) % N] == 1) return (s + k) % N;
    return -1;
  endfunction

  function automatic int exiting();
    for (int i = 0; i < N; i++) if (m_st[i] == 1 && m_y[i] + m_spd[i] >= SH) return i;
    return -1;
  endfunction

  task automatic aim(output int ax, output int ay);
    int m = pick_active();
    if (m < 0 || $urandom_range(0, 3) == 0) begin
      ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
    end else begin
      ax = m_x[m] + $urandom_range(0, 31); ay = m_y[m] + $urandom_range(0, 31);
    end
  endtask

  task automatic random_frame(input int en_pct);
    int ax0, ay0, ax1, ay1;
    aim(ax0, ay0); aim(ax1, ay1);
    frame($urandom_range(0, 99) < en_pct, 2'($urandom_range(0, 3)), ax0, ay0, ax1, ay1);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_obj_x"}, 128'(bus.obj_x), 128'(0));
    chk({pfx, "_obj_y"}, 128'(bus.obj_y), 128'(0));
    chk({pfx, "_active"}, 128'(bus.obj_active), 128'(0));
    chk({pfx, "_exploding"}, 128'(bus.obj_exploding), 128'(0));
    chk({pfx, "_ammo_hit"}, 128'(bus.ammo_hit), 128'(0));
    chk({pfx, "_pulses"}, 128'({bus.hit_pulse, bus.miss_pulse}), 128'(0));
    chk({pfx, "_hit_count"}, 128'(bus.hit_count), 128'(0));
    chk({pfx, "_lfsr"}, 128'(dut.u_lfsr.r_state), 128'(16'hACE1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int m, found, hc0;
    bit saw;
    bus.enable = 1'b0; bus.ammo_valid = '0; bus.ammo_x = '0; bus.ammo_y = '0;
    model_reset();
    #12;
    check_zero("reset");
    chk("obj_size", 128'(bus.obj_size), 128'(SZ));
    rst = 1'b0;

    // staggered spawn: one new meteor per frame, in index order
    for (int k = 0; k < N; k++) begin
      frame(1'b1, 2'b00, 0, 0, 0, 0);
      chk("spawn_seq", 128'(bus.obj_active), 128'((1 << (k + 1)) - 1));
      chk("spawn_y0", 128'(bus.obj_y[k*CW +: CW]), 128'(0));
      chk("spawn_x_range", 128'(bus.obj_x[k*CW +: CW] < 10'd610), 128'(1));
    end

    m = pick_active();
    frame(1'b1, 2'b01, m_x[m] + 15, m_y[m] + 15, 0, 0);
    chk("first_hit_pulse", 128'(bus.hit_pulse), 128'(1));
    chk("first_hit_count", 128'(bus.hit_count), 128'(1));
    chk("first_ammo_hit", 128'(bus.ammo_hit), 128'(2'b01));
    for (int k = 0; k < 8; k++) frame(1'b1, 2'b00, 0, 0, 0, 0);

    m = pick_active();
    hc0 = m_hits;
    frame(1'b1, 2'b11, m_x[m] + 15, m_y[m] + 15, m_x[m] + 20, m_y[m] + 20);
    chk("two_bullets_ahit", 128'(bus.ammo_hit), 128'(2'b11));

    m = pick_active();
    frame(1'b1, 2'b01, m_x[m], m_y[m] + 15, 0, 0);
    m = pick_active();
    frame(1'b1, 2'b10, 0, 0, m_x[m] + 15, m_y[m] + SZ);
    for (int k = 0; k < 20; k++) frame(1'b1, 2'b00, 0, 0, 0, 0);

    // shoot a meteor on the very frame it would leave the screen
    found = -1;
    for (int f = 0; f < 600 && found < 0; f++) begin
      m = exiting();
      if (m >= 0) begin
        found = m;
        frame(1'b1, 2'b01, m_x[m] + 15, m_y[m] + 15, 0, 0);
      end else frame(1'b1, 2'b00, 0, 0, 0, 0);
    end
    chk("exit_hit_found", 128'(found >= 0), 128'(1));

    saw = 0;
    for (int f = 0; f < 600 && !saw; f++) begin
      frame(1'b1, 2'b00, 0, 0, 0, 0);
      if (bus.miss_pulse === 1'b1) saw = 1;
    end
    chk("miss_seen", 128'(saw), 128'(1));

    for (int k = 0; k < 5; k++) random_frame(0);
    for (int k = 0; k < 400; k++) random_frame(90);

    #2 rst = 1'b1;
    #1 check_zero("midreset");
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) random_frame(95);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
